// File: rtl/nibble_assembler.sv
// Assembles a framed, MSB-first serial stream into 4-bit nibbles presented
// on a valid/ready output register, with sticky overrun and a delivery count.
//
// state   | meaning
// S_IDLE  | no frame open; bits without frame_start are ignored
// S_SHIFT | frame open; bits are appended, every 4th completes a nibble
module nibble_assembler #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             clr_overrun,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [CNT_W-1:0] nib_count
);

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [1:0]         bit_cnt_q, bit_cnt_d;
  logic [2:0]         shift_q, shift_d;
  logic [3:0]         nib_q, nib_d;
  logic               out_valid_q, out_valid_d;
  logic               overrun_q, overrun_d;
  logic [CNT_W-1:0]   nib_count_q, nib_count_d;

  logic               accept;
  logic               complete;
  logic               handshake;
  logic               out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 2'd0;
      shift_q     <= 3'b000;
      nib_q       <= 4'b0000;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      nib_count_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      nib_q       <= nib_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      nib_count_q <= nib_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    nib_d       = nib_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    nib_count_d = nib_count_q;

    accept    = ser_valid && (frame_start || (state_q == S_SHIFT));
    complete  = accept && !frame_start && (bit_cnt_q == 2'd3);
    handshake = out_valid_q && out_ready;
    out_free  = !out_valid_q || out_ready;

    if (accept) begin
      state_d = S_SHIFT;
      if (frame_start) begin
        // A new frame discards whatever partial nibble was in flight.
        shift_d   = {2'b00, ser_in};
        bit_cnt_d = 2'd1;
      end else begin
        shift_d   = {shift_q[1:0], ser_in};
        bit_cnt_d = bit_cnt_q + 2'd1;
      end
    end

    if (handshake) begin
      nib_count_d = nib_count_q + 1'b1;
      out_valid_d = 1'b0;
    end

    if (complete) begin
      if (out_free) begin
        nib_d       = {shift_q, ser_in};
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Set has priority over a same-cycle clear.
    if (clr_overrun && !(complete && !out_free)) begin
      overrun_d = 1'b0;
    end
  end

  assign a         = nib_q[3];
  assign b         = nib_q[2];
  assign c         = nib_q[1];
  assign d         = nib_q[0];
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign nib_count = nib_count_q;

endmodule

// File: tb/tb_nibble_assembler.sv
// Scoreboard bench for nibble_assembler: stimulus queues expected nibbles,
// a negedge monitor pops and compares them on every handshake.
module tb_nibble_assembler;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ser_in = 1'b0;
  logic             ser_valid = 1'b0;
  logic             frame_start = 1'b0;
  logic             clr_overrun = 1'b0;
  logic             out_ready = 1'b0;
  logic             a, b, c, d, out_valid, overrun;
  logic [CNT_W-1:0] nib_count;

  int n_total = 0;
  int n_pass  = 0;
  logic [3:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt;

  nibble_assembler #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .frame_start(frame_start), .clr_overrun(clr_overrun),
    .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .nib_count(nib_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: a handshake happens at the next rising edge when valid&ready here.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_nibble: got %b expected none", {a, b, c, d});
      end else begin
        chk("nibble", {28'd0, a, b, c, d}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_bit(input logic fs, input logic bit_v);
    ser_valid   = 1'b1;
    frame_start = fs;
    ser_in      = bit_v;
    @(posedge clk); #1;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_nib(input logic fs, input logic [3:0] nib);
    for (int i = 3; i >= 0; i--) send_bit(fs && (i == 3), nib[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    exp_cnt = '0;
  endtask

  initial begin
    exp_cnt = '0;
    idle(2);
    rst_n = 1'b1;

    // Reset mid-nibble, with a stalled nibble already presented.
    out_ready = 1'b0;
    send_nib(1'b1, 4'b1010);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_outputs", {24'd0, a, b, c, d, out_valid, overrun, nib_count}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    idle(1);
    chk("rst_ignore_bits", {31'd0, out_valid}, 32'd0);

    // Single nibble with latency check.
    out_ready = 1'b1;
    exp_q.push_back(4'b0010);
    send_nib(1'b1, 4'b0010);
    chk("single_latency", {27'd0, out_valid, a, b, c, d}, {27'd0, 1'b1, 4'b0010});
    idle(1);
    exp_cnt = exp_cnt + 1'b1;
    chk("single_count", {30'd0, nib_count}, {30'd0, exp_cnt});

    // Streaming: one frame_start, eight back-to-back bits.
    exp_q.push_back(4'b0111);
    exp_q.push_back(4'b1111);
    send_nib(1'b1, 4'b0111);
    send_nib(1'b0, 4'b1111);
    chk("stream_second", {27'd0, out_valid, a, b, c, d}, {27'd0, 1'b1, 4'b1111});
    idle(2);
    exp_cnt = exp_cnt + 2'd2;
    chk("stream_count", {30'd0, nib_count}, {30'd0, exp_cnt});
    chk("stream_overrun", {31'd0, overrun}, 32'd0);

    // Backpressure: second nibble dropped, overrun sticky.
    out_ready = 1'b0;
    exp_q.push_back(4'b0010);
    send_nib(1'b1, 4'b0010);
    send_nib(1'b0, 4'b0111);
    idle(1);
    chk("bp_hold", {27'd0, out_valid, a, b, c, d}, {27'd0, 1'b1, 4'b0010});
    chk("bp_overrun", {31'd0, overrun}, 32'd1);
    chk("bp_count_held", {30'd0, nib_count}, {30'd0, exp_cnt});
    out_ready = 1'b1;
    idle(1);
    exp_cnt = exp_cnt + 1'b1;
    chk("bp_count", {30'd0, nib_count}, {30'd0, exp_cnt});
    chk("bp_valid_clear", {31'd0, out_valid}, 32'd0);
    chk("bp_overrun_sticky", {31'd0, overrun}, 32'd1);
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    chk("bp_overrun_clr", {31'd0, overrun}, 32'd0);

    // Re-frame discards the partial "10".
    exp_q.push_back(4'b1111);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_nib(1'b1, 4'b1111);
    chk("reframe_nib", {27'd0, out_valid, a, b, c, d}, {27'd0, 1'b1, 4'b1111});
    idle(2);
    exp_cnt = exp_cnt + 1'b1;
    chk("reframe_count", {30'd0, nib_count}, {30'd0, exp_cnt});

    // Counter wrap: five handshakes from reset on a 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(4'(i + 3));
      send_nib(i == 0, 4'(i + 3));
    end
    idle(2);
    chk("wrap_count", {30'd0, nib_count}, 32'd1);

    // Overrun set beats a same-cycle clear.
    out_ready = 1'b0;
    exp_q.push_back(4'b0011);
    send_nib(1'b0, 4'b0011);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    clr_overrun = 1'b1;
    send_bit(1'b0, 1'b1);
    clr_overrun = 1'b0;
    chk("set_beats_clr", {31'd0, overrun}, 32'd1);
    chk("set_beats_hold", {28'd0, a, b, c, d}, 32'h3);
    out_ready = 1'b1;
    idle(2);
    chk("final_count", {30'd0, nib_count}, 32'd2);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/nibble_assembler.md
# nibble_assembler

Upstream stage for the 4-input SOP/POS decode logic. It accepts a framed, MSB-first serial bit stream and assembles 4-bit nibbles. Each completed nibble is presented as the four individual bits a, b, c, d, which drive the decode logic's inputs directly. A valid/ready output register holds each nibble until the consumer takes it. The block also reports overrun and keeps a count of delivered nibbles.

## Interface
Parameters:
- CNT_W, default 8, width of the delivered-nibble counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ser_in  input  1  serial data bit, sampled when ser_valid=1.
- ser_valid  input  1  ser_in carries a bit this cycle.
- frame_start  input  1  with ser_valid=1, marks this bit as MSB of a new nibble.
- clr_overrun  input  1  synchronous clear of the overrun flag.
- a  output  1  nibble bit 3 (MSB, first bit received).
- b  output  1  nibble bit 2.
- c  output  1  nibble bit 1.
- d  output  1  nibble bit 0 (LSB, fourth bit received).
- out_valid  output  1  a, b, c, d hold a complete nibble.
- out_ready  input  1  consumer accepts the nibble when out_valid and out_ready are both 1 at a rising edge.
- overrun  output  1  sticky; a completed nibble was dropped because the output register was occupied.
- nib_count  output  CNT_W  count of accepted handshakes, wraps modulo 2^CNT_W.

## Operation
- State machine with two states, IDLE and SHIFT, plus a 2-bit bit counter (bit_cnt) and a 3-bit shift register.
- IDLE:
  - ser_valid=1 and frame_start=0: bit ignored.
  - ser_valid=1 and frame_start=1: bit stored as MSB, bit_cnt=1, go to SHIFT.
- SHIFT:
  - ser_valid=0: hold all state.
  - ser_valid=1 and frame_start=1: partial nibble discarded; bit stored as the new MSB, bit_cnt=1.
  - ser_valid=1 and frame_start=0: bit appended, bit_cnt increments.
- Fourth bit (bit_cnt=3 and the bit accepted):
  - The nibble {shift[2:0], ser_in} is complete and bit_cnt returns to 0.
  - The state stays SHIFT, so the next bit without frame_start begins the next nibble (continuous streaming).
- Output register is free when out_valid=0, or when out_valid=1 and out_ready=1 in the same cycle.
  - Free on the completion cycle: load {a,b,c,d} with the nibble; out_valid=1.
  - Not free: nibble dropped, overrun set to 1, output register unchanged.
- Handshake:
  - On out_valid & out_ready with no new nibble loading, out_valid clears.
  - nib_count increments on every accepted handshake.
  - The output register never changes while out_valid=1 and out_ready=0.
- overrun:
  - Clears on clr_overrun=1.
  - If an overrun event and clr_overrun occur in the same cycle, set wins.
- Reset (asserted at any time, including mid-nibble): state IDLE, bit_cnt=0, shift=000, a=b=c=d=0, out_valid=0, overrun=0, nib_count=0. Any partial nibble is lost.

## Timing
- Latency: 4th bit sampled at edge k → a..d and out_valid valid after edge k (1 cycle from bit to output).
- Throughput: one nibble per 4 ser_valid cycles. Bubbles (ser_valid=0) are allowed anywhere in a nibble.
- Simultaneous completion and handshake at edge k: the old nibble is consumed (nib_count+1), the new nibble loads, and out_valid stays 1 with no bubble.
- out_valid, a..d, overrun and nib_count are registered outputs with no combinational path from inputs.
- out_ready may depend combinationally on a..d (the downstream decode logic is combinational); no loop exists because the outputs are registered.
- nib_count wraps from 2^CNT_W−1 to 0 without a flag.
- rst_n deassertion takes effect at the first rising edge after release. Inputs are sampled from that edge.

## Test plan
- Reset mid-nibble: send frame_start+1, then 0, then assert rst_n=0. Required: all outputs 0 immediately. After release, bits 1,1 without frame_start are ignored and out_valid stays 0.
- Single nibble: frame_start with bits 0,0,1,0 and out_ready=1. Required: a,b,c,d=0,0,1,0 and out_valid=1 one cycle after the 4th bit; nib_count=1 after the handshake.
- Streaming: frame_start once, then 8 consecutive bits 0111 1111 with out_ready=1. Required: nibble 0111 followed by 1111, no bubble between them; nib_count=2; overrun=0.
- Backpressure: out_ready=0, stream nibbles 0010 then 0111. Required: a..d held at 0010, second nibble dropped, overrun=1. Then out_ready=1: handshake occurs, nib_count=1, overrun stays 1 until clr_overrun.
- Re-frame: frame_start+1, bit 0, then frame_start+1 with bits 1,1,1. Required: output nibble 1111; the partial nibble "10" never appears.
- Counter wrap: with CNT_W=2, perform 5 handshakes. Required: nib_count=1. Also check clr_overrun asserted in the same cycle as an overrun event: overrun=1.
